// File: rtl/sqrt_arbiter_if.sv
// Bundle of the requester-side handshake and the shared square-root unit port
// of sqrt_arbiter. The arbiter takes the slave view; the environment the master.
interface sqrt_arbiter_if;
    logic [3:0]  req_i;
    logic [71:0] x_bi;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic [3:0]  ack_i;
    logic [8:0]  y_bo;
    logic        busy_o;
    logic        err_o;
    logic        sq_start_o;
    logic [17:0] sq_x_bo;
    logic [8:0]  sq_y_bi;
    logic        sq_busy_i;

    modport slave (
        input  req_i, x_bi, ack_i, sq_y_bi, sq_busy_i,
        output gnt_o, done_o, y_bo, busy_o, err_o, sq_start_o, sq_x_bo
    );

    modport master (
        output req_i, x_bi, ack_i, sq_y_bi, sq_busy_i,
        input  gnt_o, done_o, y_bo, busy_o, err_o, sq_start_o, sq_x_bo
    );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one 18-bit integer square-root unit between four
// requesters; results are held per requester until acknowledged.
module sqrt_arbiter #(
    parameter int START_TMO = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    sqrt_arbiter_if.slave bus
);

    localparam int CW = (START_TMO < 1) ? 1 : $clog2(START_TMO + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(START_TMO - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DELIVER = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [1:0]    rr_r, rr_s;
    logic [1:0]    id_r, id_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    gnt_r, gnt_s;
    logic [3:0]    done_r, done_s;
    logic [8:0]    y_r, y_s;
    logic          err_r, err_s;
    logic          start_r, start_s;
    logic          busy_r, busy_s;
    logic [17:0]   xop_r, xop_s;
    logic [2:0]    pick_s;
    logic [6:0]    base_s;

    // Returns {found, index}: first set request at or after ptr, wrapping 3->0.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s = rr_pick(bus.req_i, rr_r);
    assign base_s = 7'd18 * {5'd0, pick_s[1:0]};

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s = state_r;
        rr_s    = rr_r;
        id_s    = id_r;
        cnt_s   = cnt_r;
        gnt_s   = 4'b0000;
        done_s  = done_r;
        y_s     = y_r;
        err_s   = err_r;
        start_s = 1'b0;
        xop_s   = xop_r;
        case (state_r)
            IDLE: begin
                if (pick_s[2] && !bus.sq_busy_i) begin
                    id_s    = pick_s[1:0];
                    xop_s   = bus.x_bi[base_s +: 18];
                    gnt_s   = 4'b0001 << pick_s[1:0];
                    start_s = 1'b1;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                cnt_s   = '0;
                state_s = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.sq_busy_i) begin
                    state_s = WAIT_LO;
                end else if (cnt_r == TMO_LAST) begin
                    // Unit never acknowledged the start: deliver a zero result and flag it.
                    err_s   = 1'b1;
                    y_s     = 9'd0;
                    done_s  = 4'b0001 << id_r;
                    state_s = DELIVER;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.sq_busy_i) begin
                    y_s     = bus.sq_y_bi;
                    done_s  = 4'b0001 << id_r;
                    state_s = DELIVER;
                end else begin
                    state_s = WAIT_LO;
                end
            end
            DELIVER: begin
                if (bus.ack_i[id_r]) begin
                    done_s  = 4'b0000;
                    rr_s    = id_r + 2'd1;
                    state_s = IDLE;
                end else begin
                    state_s = DELIVER;
                end
            end
            default: begin
                state_s = IDLE;
                done_s  = 4'b0000;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
            rr_r    <= 2'd0;
            id_r    <= 2'd0;
            cnt_r   <= '0;
            gnt_r   <= 4'b0000;
            done_r  <= 4'b0000;
            y_r     <= 9'd0;
            err_r   <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            xop_r   <= 18'd0;
        end else begin
            state_r <= state_s;
            rr_r    <= rr_s;
            id_r    <= id_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            y_r     <= y_s;
            err_r   <= err_s;
            start_r <= start_s;
            busy_r  <= busy_s;
            xop_r   <= xop_s;
        end
    end

    assign bus.gnt_o      = gnt_r;
    assign bus.done_o     = done_r;
    assign bus.y_bo       = y_r;
    assign bus.busy_o     = busy_r;
    assign bus.err_o      = err_r;
    assign bus.sq_start_o = start_r;
    assign bus.sq_x_bo    = xop_r;

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 The block SHALL have parameter START_TMO, default 4, meaning the maximum number of cycles to wait for sq_busy_i to rise after a start.
REQ-002 The block SHALL have port clk_i, input, 1, system clock; all flops update on its rising edge.
REQ-003 The block SHALL have port rstn_i, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req_i, input, 4, per-requester request; the requester holds it and its operand until granted.
REQ-005 The block SHALL have port x_bi, input, 72, operands; requester k uses bits [18k+17:18k].
REQ-006 The block SHALL have port gnt_o, output, 4, one-hot one-cycle pulse: the request is accepted.
REQ-007 The block SHALL have port done_o, output, 4, one-hot result-valid; held until acknowledged.
REQ-008 The block SHALL have port ack_i, input, 4, per-requester result acknowledge.
REQ-009 The block SHALL have port y_bo, output, 9, result of the delivered job.
REQ-010 The block SHALL have port busy_o, output, 1; it is high whenever state is not IDLE.
REQ-011 The block SHALL have port err_o, output, 1, sticky start-timeout flag.
REQ-012 The block SHALL have ports sq_start_o (output, 1), sq_x_bo (output, 18), sq_y_bi (input, 9) and sq_busy_i (input, 1), connected to the shared 18-bit integer square-root unit.

Function
REQ-013 The FSM SHALL have states IDLE, START, WAIT_HI, WAIT_LO and DELIVER.
REQ-014 IDLE SHALL grant only when at least one req_i bit is set and sq_busy_i is 0; otherwise it stays in IDLE.
REQ-015 Grant selection SHALL be round-robin: search upward from pointer rr with wrap 3->0, and the first set bit wins.
REQ-016 On a grant at edge E, the block SHALL latch the winner id and operand, and enter START for the cycle after E.
REQ-017 In START, gnt_o[id]=1 and sq_start_o=1 for exactly one cycle, with sq_x_bo equal to the latched operand; next state SHALL be WAIT_HI.
REQ-018 WAIT_HI: when sq_busy_i=1, the next state SHALL be WAIT_LO; otherwise a counter increments.
REQ-019 WAIT_HI timeout: if the counter reaches START_TMO with sq_busy_i still 0, the block SHALL set err_o, load y_bo=0, assert done_o[id] and go to DELIVER.
REQ-020 WAIT_LO: when sq_busy_i=0, the block SHALL capture sq_y_bi into y_bo, assert done_o[id] and go to DELIVER in the same edge.
REQ-021 DELIVER: y_bo and done_o SHALL be held stable; ack_i[id]=1 clears done_o, sets rr=(id+1) mod 4 and returns to IDLE.
REQ-022 In DELIVER, ack_i bits other than id SHALL be ignored.
REQ-023 Requests arriving while busy_o=1 SHALL wait, with no loss and no queueing beyond req_i itself.
REQ-024 A req_i drop before grant SHALL simply withdraw the request; no grant is issued for it.
REQ-025 sq_start_o SHALL never be asserted outside START.
REQ-026 gnt_o and done_o SHALL never have more than one bit set.
REQ-027 All outputs SHALL be registered.
REQ-028 Latency from the grant edge to done_o SHALL be 1 + (cycles until busy rises) + (sqrt busy duration) cycles.

Reset
REQ-029 rstn_i low SHALL asynchronously force state=IDLE, rr=0, counter=0, gnt_o=0, done_o=0, y_bo=0, busy_o=0, err_o=0, sq_start_o=0 and sq_x_bo=0.
REQ-030 Reset mid-job SHALL discard the job without a done_o pulse.
REQ-031 After reset, no grant SHALL occur until sq_busy_i is 0 (REQ-014).
REQ-032 err_o SHALL clear only on reset.

Verification
REQ-033 Single job: req_i=0001, x=144 -> gnt_o=0001 for 1 cycle, sq_start_o with sq_x_bo=144, later done_o=0001 and y_bo=12 held until ack_i=0001.
REQ-034 Round-robin: req_i=1111 held with immediate acks -> grant order 0,1,2,3,0; then req_i=0101 after serving 0 -> next grant is 2.
REQ-035 Boundaries: x=0 -> y_bo=0; x=262143 -> y_bo=511; x=1 -> y_bo=1.
REQ-036 Timeout: sqrt model never raises busy -> after START_TMO=4 cycles in WAIT_HI, err_o=1, done_o[id]=1, y_bo=0; err_o persists through the next good job.
REQ-037 Reset mid-operation: rstn_i low during WAIT_LO -> all outputs reset immediately; with sq_busy_i still 1 and req_i=0010, no grant until sq_busy_i falls.
REQ-038 Held done: ack_i withheld 10 cycles, other req_i asserted -> y_bo and done_o stable, no new gnt_o until the correct ack; wrong-bit ack_i is ignored.
